// File: rtl/store_seq_pkg.sv
// Shared types, constants and decode helpers for the store sequencer.
package store_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC0 = 2'd1,
        ACC1 = 2'd2,
        FIN  = 2'd3
    } state_e;

    localparam logic [2:0] F3_SB    = 3'b000;
    localparam logic [2:0] F3_SH    = 3'b001;
    localparam logic [2:0] F3_SW    = 3'b010;
    localparam logic [3:0] WEB_NONE = 4'b1111;

    function automatic logic is_supported(input logic [2:0] f3);
        return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
    endfunction

    function automatic logic [3:0] type_mask(input logic [2:0] f3);
        case (f3)
            F3_SB:   return 4'b0001;
            F3_SH:   return 4'b0011;
            F3_SW:   return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    // A store crosses a word boundary when its lanes spill past byte 3.
    function automatic logic is_split(input logic [2:0] f3, input logic [1:0] off);
        return ((f3 == F3_SH) && (off == 2'd3)) || ((f3 == F3_SW) && (off != 2'd0));
    endfunction

endpackage

// File: rtl/store_lane_gen.sv
// Word address, byte write-enable and lane-positioned data for either half of a store.
module store_lane_gen
    import store_seq_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic        half_i,
    output logic [31:0] addr_o,
    output logic [3:0]  we_o,
    output logic [31:0] di_o
);

    logic [1:0]  off;
    logic [5:0]  sh_lo;
    logic [5:0]  sh_hi;
    logic [7:0]  mask_wide;
    logic [31:0] base;

    assign off   = addr_i[1:0];
    assign sh_lo = {1'b0, off, 3'b000};
    assign sh_hi = 6'd32 - sh_lo;
    assign base  = {addr_i[31:2], 2'b00};

    // The upper nibble of the widened, shifted mask is exactly mask >> (4-off).
    assign mask_wide = {4'b0000, type_mask(funct3_i)} << off;

    always_comb begin
        addr_o = base;
        we_o   = mask_wide[3:0];
        di_o   = wdata_i << sh_lo;
        if (half_i) begin
            addr_o = base + 32'd4;
            we_o   = mask_wide[7:4];
            di_o   = wdata_i >> sh_hi;
        end
    end

endmodule

// File: rtl/store_sequencer.sv
// Sequences a byte/half/word store into one or two aligned word accesses.
// Macro STORE_SPLIT_EN enables the second access; without it split stores are dropped with misalign_err.
//
// state | meaning
// IDLE  | ready for a request
// ACC0  | first (or only) word access, waiting for mem_ack
// ACC1  | second word access of a split store
// FIN   | one-cycle completion, done pulses
module store_sequencer
    import store_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_web,
    output logic [31:0] mem_di,
    input  logic        mem_ack,
    output logic        done,
    output logic        misalign_err
);

    state_e      state_q, state_d;
    logic [2:0]  f3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        accept;
    logic        req_split;
    logic        half;
    logic [31:0] lane_addr;
    logic [3:0]  lane_we;
    logic [31:0] lane_di;

    assign accept    = req_valid && (state_q == IDLE);
    assign req_split = is_split(req_funct3, req_addr[1:0]);

`ifdef STORE_SPLIT_EN
    logic split_q;
`else
    logic err_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            f3_q    <= 3'b000;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
`ifdef STORE_SPLIT_EN
            split_q <= 1'b0;
`else
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            if (accept) begin
                f3_q    <= req_funct3;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
`ifdef STORE_SPLIT_EN
                split_q <= req_split;
`else
                err_q   <= is_supported(req_funct3) && req_split;
`endif
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
`ifdef STORE_SPLIT_EN
                    state_d = is_supported(req_funct3) ? ACC0 : FIN;
`else
                    state_d = (is_supported(req_funct3) && !req_split) ? ACC0 : FIN;
`endif
                end
            end
            ACC0: begin
                if (mem_ack) begin
`ifdef STORE_SPLIT_EN
                    state_d = split_q ? ACC1 : FIN;
`else
                    state_d = FIN;
`endif
                end
            end
`ifdef STORE_SPLIT_EN
            ACC1: begin
                if (mem_ack) state_d = FIN;
            end
`endif
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

`ifdef STORE_SPLIT_EN
    assign half = (state_q == ACC1);
`else
    assign half = 1'b0;
`endif

    store_lane_gen u_lane_gen (
        .funct3_i (f3_q),
        .addr_i   (addr_q),
        .wdata_i  (wdata_q),
        .half_i   (half),
        .addr_o   (lane_addr),
        .we_o     (lane_we),
        .di_o     (lane_di)
    );

    always_comb begin
        req_ready    = (state_q == IDLE);
        mem_req      = (state_q == ACC0) || (state_q == ACC1);
        mem_addr     = 32'd0;
        mem_web      = WEB_NONE;
        mem_di       = 32'd0;
        done         = (state_q == FIN);
        misalign_err = 1'b0;
        if (mem_req) begin
            mem_addr = lane_addr;
            mem_web  = ~lane_we;
            mem_di   = lane_di;
        end
`ifndef STORE_SPLIT_EN
        misalign_err = (state_q == FIN) && err_q;
`endif
    end

endmodule

// File: tb/tb_store_sequencer.sv
// Directed bench for store_sequencer; expectations follow whether STORE_SPLIT_EN is defined.
module tb_store_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [3:0]  mem_web;
    logic [31:0] mem_di;
    logic        mem_ack;
    logic        done;
    logic        misalign_err;

    int n_chk  = 0;
    int n_pass = 0;

    logic [31:0] c_addr [2];
    logic [3:0]  c_web  [2];
    logic [31:0] c_di   [2];
    int          lat, nacc;
    logic        err, stable, ready_seen;

    always #5 clk = ~clk;

    store_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_funct3   (req_funct3),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_web      (mem_web),
        .mem_di       (mem_di),
        .mem_ack      (mem_ack),
        .done         (done),
        .misalign_err (misalign_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one store, ack each access after `waits` idle cycles, record the accesses,
    // then step back to IDLE. lat counts cycles from the accept edge to done.
    task automatic do_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                            input int waits, input bit noise);
        int wc;
        wc = 0; lat = 0; nacc = 0; err = 1'b0; stable = 1'b1; ready_seen = 1'b0;
        for (int i = 0; i < 2; i++) begin
            c_addr[i] = 32'hx; c_web[i] = 4'hx; c_di[i] = 32'hx;
        end
        req_valid = 1'b1; req_funct3 = f3; req_addr = a; req_wdata = d;
        tick();
        if (noise) begin
            req_funct3 = 3'b111; req_addr = 32'h0000_0DEA; req_wdata = 32'h5A5A_5A5A;
        end else begin
            req_valid = 1'b0;
        end
        for (int cyc = 1; cyc <= 20; cyc++) begin
            if (done) begin
                lat = cyc; err = misalign_err;
                break;
            end
            if (req_ready) ready_seen = 1'b1;
            if (mem_req && nacc < 2) begin
                if (wc == 0) begin
                    c_addr[nacc] = mem_addr; c_web[nacc] = mem_web; c_di[nacc] = mem_di;
                end else if (mem_addr !== c_addr[nacc] || mem_web !== c_web[nacc] || mem_di !== c_di[nacc]) begin
                    stable = 1'b0;
                end
                if (wc == waits) begin
                    mem_ack = 1'b1; nacc++; wc = 0;
                end else begin
                    wc++;
                end
            end
            tick();
            mem_ack = 1'b0;
        end
        req_valid = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_funct3 = 3'b000; req_addr = 32'd0;
        req_wdata = 32'd0; mem_ack = 1'b0;
        tick();
        tick();
        chk("rst_ready",   32'(req_ready),    32'd1);
        chk("rst_mem_req", 32'(mem_req),      32'd0);
        chk("rst_web",     32'(mem_web),      32'hF);
        chk("rst_addr",    mem_addr,          32'd0);
        chk("rst_di",      mem_di,            32'd0);
        chk("rst_done",    32'(done),         32'd0);
        chk("rst_err",     32'(misalign_err), 32'd0);
        rst = 1'b0;
        tick();

        // SW aligned, immediate ack
        do_store(3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 0, 1'b0);
        chk("sw_lat",  32'(lat),  32'd2);
        chk("sw_nacc", 32'(nacc), 32'd1);
        chk("sw_addr", c_addr[0], 32'h0000_0100);
        chk("sw_web",  32'(c_web[0]), 32'h0);
        chk("sw_di",   c_di[0],   32'hDEAD_BEEF);
        chk("sw_err",  32'(err),  32'd0);
        chk("sw_idle_ready", 32'(req_ready), 32'd1);
        chk("sw_done_pulse", 32'(done),      32'd0);

        // SB at top byte lane
        do_store(3'b000, 32'h0000_0103, 32'h0000_00AB, 0, 1'b0);
        chk("sb_lat",  32'(lat),      32'd2);
        chk("sb_addr", c_addr[0],     32'h0000_0100);
        chk("sb_web",  32'(c_web[0]), 32'h7);
        chk("sb_di",   c_di[0],       32'hAB00_0000);

        // SH at offset 2 stays in one word
        do_store(3'b001, 32'h0000_0102, 32'h0000_BEEF, 0, 1'b0);
        chk("sh2_lat",  32'(lat),      32'd2);
        chk("sh2_nacc", 32'(nacc),     32'd1);
        chk("sh2_web",  32'(c_web[0]), 32'h3);
        chk("sh2_di",   c_di[0],       32'hBEEF_0000);

        // unsupported funct3
        do_store(3'b011, 32'h0000_0100, 32'h1111_1111, 0, 1'b0);
        chk("bad_lat",  32'(lat),  32'd1);
        chk("bad_nacc", 32'(nacc), 32'd0);
        chk("bad_err",  32'(err),  32'd0);

        // SH at offset 3
        do_store(3'b001, 32'h0000_0203, 32'h0000_1234, 0, 1'b0);
`ifdef STORE_SPLIT_EN
        chk("sh3_lat",   32'(lat),      32'd3);
        chk("sh3_nacc",  32'(nacc),     32'd2);
        chk("sh3_addr0", c_addr[0],     32'h0000_0200);
        chk("sh3_web0",  32'(c_web[0]), 32'h7);
        chk("sh3_di0",   c_di[0],       32'h3400_0000);
        chk("sh3_addr1", c_addr[1],     32'h0000_0204);
        chk("sh3_web1",  32'(c_web[1]), 32'hE);
        chk("sh3_di1",   c_di[1],       32'h0000_0012);
        chk("sh3_err",   32'(err),      32'd0);
`else
        chk("sh3_lat",  32'(lat),  32'd1);
        chk("sh3_nacc", 32'(nacc), 32'd0);
        chk("sh3_err",  32'(err),  32'd1);
`endif

        // SW wrapping the address space, two wait cycles per access, req_valid held high
        do_store(3'b010, 32'hFFFF_FFFE, 32'h1122_3344, 2, 1'b1);
`ifdef STORE_SPLIT_EN
        chk("wrap_lat",    32'(lat),        32'd7);
        chk("wrap_nacc",   32'(nacc),       32'd2);
        chk("wrap_addr0",  c_addr[0],       32'hFFFF_FFFC);
        chk("wrap_web0",   32'(c_web[0]),   32'h3);
        chk("wrap_di0",    c_di[0],         32'h3344_0000);
        chk("wrap_addr1",  c_addr[1],       32'h0000_0000);
        chk("wrap_web1",   32'(c_web[1]),   32'hC);
        chk("wrap_di1",    c_di[1],         32'h0000_1122);
        chk("wrap_stable", 32'(stable),     32'd1);
        chk("wrap_busy",   32'(ready_seen), 32'd0);
`else
        chk("wrap_lat",  32'(lat),  32'd1);
        chk("wrap_nacc", 32'(nacc), 32'd0);
        chk("wrap_err",  32'(err),  32'd1);
`endif

        // SW at offset 1
        do_store(3'b010, 32'h0000_0001, 32'hA1B2_C3D4, 0, 1'b0);
`ifdef STORE_SPLIT_EN
        chk("sw1_lat",   32'(lat),      32'd3);
        chk("sw1_addr0", c_addr[0],     32'h0000_0000);
        chk("sw1_web0",  32'(c_web[0]), 32'h1);
        chk("sw1_di0",   c_di[0],       32'hB2C3_D400);
        chk("sw1_addr1", c_addr[1],     32'h0000_0004);
        chk("sw1_web1",  32'(c_web[1]), 32'hE);
        chk("sw1_di1",   c_di[1],       32'h0000_00A1);
        chk("sw1_err",   32'(err),      32'd0);
`else
        chk("sw1_lat",  32'(lat),  32'd1);
        chk("sw1_nacc", 32'(nacc), 32'd0);
        chk("sw1_err",  32'(err),  32'd1);
`endif

        // reset on the same cycle as mem_ack, mid-access
        req_valid = 1'b1; req_funct3 = 3'b001; req_addr = 32'h0000_0203; req_wdata = 32'h0000_1234;
        tick();
        req_valid = 1'b0;
`ifdef STORE_SPLIT_EN
        mem_ack = 1'b1;
        tick();
        chk("ra_in_acc1", mem_addr, 32'h0000_0204);
`else
        req_funct3 = 3'b000;
`endif
        mem_ack = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0; mem_ack = 1'b0;
        chk("ra_ready",   32'(req_ready), 32'd1);
        chk("ra_mem_req", 32'(mem_req),   32'd0);
        chk("ra_web",     32'(mem_web),   32'hF);
        chk("ra_done",    32'(done),      32'd0);
        tick();
        chk("ra_no_done", 32'(done),      32'd0);

        do_store(3'b000, 32'h0000_0101, 32'h0000_0055, 0, 1'b0);
        chk("post_lat",  32'(lat),      32'd2);
        chk("post_addr", c_addr[0],     32'h0000_0100);
        chk("post_web",  32'(c_web[0]), 32'hD);
        chk("post_di",   c_di[0],       32'h0000_5500);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/store_sequencer.md
STORE_SEQUENCER -- requirements
Module: store_sequencer

Interface
REQ-001 The block SHALL have these ports (name, direction, width, meaning), clock and reset first:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  store request present.
- req_ready  out  1  block can accept a request.
- req_funct3  in  3  store type: 000 SB, 001 SH, 010 SW.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- mem_req  out  1  memory access active.
- mem_addr  out  32  word address; bits [1:0] always 00.
- mem_web  out  4  active-low byte write enables: 0 = write lane, 1 = keep.
- mem_di  out  32  lane-positioned write data.
- mem_ack  in  1  memory accepted the current access.
- done  out  1  one-cycle pulse; the store is complete.
- misalign_err  out  1  one-cycle pulse with done; the store was dropped (STORE_SPLIT_EN undefined only).
REQ-002 The block SHALL use one clock, clk, and one synchronous active-high reset, rst.

Function
REQ-003 The FSM states SHALL be IDLE, ACC0, ACC1 and FIN.
REQ-004 req_ready SHALL be 1 only in IDLE, and a request SHALL be accepted on req_valid && req_ready, with funct3, addr and wdata latched.
REQ-005 Accept SHALL move IDLE to ACC0, except for an unsupported funct3, which goes to FIN with no memory access.
REQ-006 In ACC0 and ACC1, mem_req SHALL be 1 and mem_addr, mem_web and mem_di SHALL hold stable until mem_ack is sampled 1.
REQ-007 With off = addr[1:0], a store SHALL be split when: SH with off = 3, or SW with off != 0.
REQ-008 On mem_ack in ACC0, the FSM SHALL go to ACC1 if the store is split, else to FIN; on mem_ack in ACC1 it SHALL go to FIN.
REQ-009 FIN SHALL last one cycle, pulse done = 1, then return to IDLE.
REQ-010 ACC0 SHALL use mem_addr = {addr[31:2],00}, write-enable (active-high) = type mask (SB 0001, SH 0011, SW 1111) shifted left by off and truncated to 4 bits, and mem_di = wdata << 8*off; mem_web is the bitwise inverse of this write-enable.
REQ-011 ACC1 SHALL use mem_addr = ACC0 address + 4 mod 2^32 (0xFFFFFFFC wraps to 0x00000000), write-enable = type mask >> (4-off), and mem_di = wdata >> 8*(4-off).
REQ-012 Whenever mem_req = 0, mem_web SHALL be 1111 and mem_di SHALL be 0.
REQ-013 Latency from accept at cycle T with zero-wait ack: unsplit done at T+2; split done at T+3; each wait cycle on mem_ack adds 1.
REQ-014 An unsupported funct3 SHALL produce done at T+1 with no mem_req and no misalign_err.
REQ-015 A req_valid arriving outside IDLE SHALL be ignored until req_ready = 1; there is no queuing.

Reset
REQ-016 rst = 1 SHALL force, at the next edge: state IDLE, req_ready 1, mem_req 0, mem_web 1111, mem_addr 0, mem_di 0, done 0, misalign_err 0.
REQ-017 rst SHALL have priority over all other inputs, including mid-access and while mem_ack = 1 in the same cycle.
REQ-018 An in-flight store SHALL be abandoned on reset, with no done pulse.

Configuration
REQ-019 With macro STORE_SPLIT_EN defined, split stores SHALL follow REQ-007 to REQ-011.
REQ-020 With STORE_SPLIT_EN undefined, split stores SHALL skip ACC0 and ACC1, go directly to FIN, and pulse done and misalign_err together with no mem_req.
REQ-021 With STORE_SPLIT_EN undefined, ACC1 SHALL not be generated.

Structure
REQ-022 Package store_seq_pkg SHALL hold the state enum and the constants F3_SB, F3_SH, F3_SW and WEB_NONE = 4'b1111.
REQ-023 Combinational lane/data generation (REQ-010, REQ-011) SHALL be the sub-module store_lane_gen, instantiated once, with a half-select input choosing ACC0 or ACC1.

Verification
REQ-024 SW, addr 0x100, data 0xDEADBEEF, ack immediate -> one access: mem_addr 0x100, mem_web 0000, mem_di 0xDEADBEEF; done at T+2.
REQ-025 SB, addr 0x103, data 0x000000AB -> mem_addr 0x100, mem_web 0111, mem_di 0xAB000000.
REQ-026 SH, addr 0x203, data 0x1234, split enabled -> access 1: addr 0x200, web 0111, di 0x34000000; access 2: addr 0x204, web 1110, di 0x00000012; done at T+3.
REQ-027 SW, addr 0xFFFFFFFE, data 0x11223344, mem_ack delayed 2 cycles per access -> access 1: addr 0xFFFFFFFC, web 0011, outputs stable while waiting; access 2: addr 0x00000000, web 1100, di 0x00001122; done at T+7.
REQ-028 rst asserted in ACC1 in the same cycle as mem_ack -> next cycle IDLE, mem_web 1111, no done; a following request is accepted normally.
REQ-029 STORE_SPLIT_EN undefined, SW at addr 0x001 -> no mem_req; done and misalign_err pulse at T+1.
